// File: rtl/mem_pkg.sv
// Shared memory-side definitions: funct3 access sizes and the store-buffer entry layout.
package mem_pkg;

   localparam int MEM_AW = 12;
   localparam int MEM_DW = 32;

   localparam logic [2:0] SZ_B  = 3'b000;
   localparam logic [2:0] SZ_H  = 3'b001;
   localparam logic [2:0] SZ_W  = 3'b010;
   localparam logic [2:0] SZ_BU = 3'b100;
   localparam logic [2:0] SZ_HU = 3'b101;

   typedef struct packed {
      logic [MEM_AW-1:0] addr;
      logic [MEM_DW-1:0] data;
      logic [2:0]        size;
      logic              valid;
   } sb_entry_t;

   // Word-granular compare: any byte of the same 32-bit word counts as a match.
   function automatic logic same_word(input logic [MEM_AW-1:0] a, input logic [MEM_AW-1:0] b);
      return a[MEM_AW-1:2] == b[MEM_AW-1:2];
   endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Core-side store/load handshake plus memory-port signals of the store buffer.
// Optional forwarding outputs exist only when SB_FWD_EN is defined.
interface store_buffer_if #(
   parameter int AW = mem_pkg::MEM_AW,
   parameter int DW = mem_pkg::MEM_DW
);
   logic          st_valid;
   logic [AW-1:0] st_addr;
   logic [DW-1:0] st_data;
   logic [2:0]    st_size;
   logic          st_ready;
   logic          ld_req;
   logic [AW-1:0] ld_addr;
   logic [2:0]    ld_size;
   logic          ld_stall;
   logic          sb_empty;
   logic          mem_read;
   logic          mem_write;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [2:0]    mem_size;
`ifdef SB_FWD_EN
   logic          fwd_valid;
   logic [DW-1:0] fwd_data;
`endif

   modport slave (
      input  st_valid, st_addr, st_data, st_size, ld_req, ld_addr, ld_size,
`ifdef SB_FWD_EN
      output fwd_valid, fwd_data,
`endif
      output st_ready, ld_stall, sb_empty, mem_read, mem_write, mem_addr, mem_wdata, mem_size
   );

   modport master (
      output st_valid, st_addr, st_data, st_size, ld_req, ld_addr, ld_size,
`ifdef SB_FWD_EN
      input  fwd_valid, fwd_data,
`endif
      input  st_ready, ld_stall, sb_empty, mem_read, mem_write, mem_addr, mem_wdata, mem_size
   );

endinterface

// File: rtl/sb_fifo.sv
// Store-buffer storage: circular entry array with pointers and occupancy count.
// Entries are also presented in age order (index 0 = head) for the load-hit scan.
module sb_fifo import mem_pkg::*; #(
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  logic                    pop,
   input  sb_entry_t               wr_entry,
   output sb_entry_t [DEPTH-1:0]   by_age,
   output logic [CW-1:0]           count,
   output logic                    full,
   output logic                    empty
);
   localparam int PW = $clog2(DEPTH);

   sb_entry_t [DEPTH-1:0] slots;
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the entry array is reset because the hit scan reads every valid bit; stale entries would stall loads.
         slots  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (pop) begin
            slots[rd_ptr].valid <= 1'b0;
            rd_ptr              <= rd_ptr + 1'b1;
         end
         if (push) begin
            slots[wr_ptr] <= wr_entry;
            wr_ptr        <= wr_ptr + 1'b1;
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         by_age[i] = slots[rd_ptr + PW'(i)];
      end
   end

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer: queues stores, drains them when the memory port is free,
// and stalls loads that hit a queued word. Define SB_FWD_EN to forward a queued SW to an LW.
module store_buffer import mem_pkg::*; #(
   parameter int DEPTH = 4
) (
   input logic           clk,
   input logic           rst,
   store_buffer_if.slave bus
);
   localparam int CW = $clog2(DEPTH) + 1;

   sb_entry_t [DEPTH-1:0] queue;
   sb_entry_t             wr_entry;
   logic [CW-1:0]         count;
   logic                  full;
   logic                  empty;
   logic                  push;
   logic                  drain;
   logic                  hit_any;
   logic                  hit;
   logic                  port_free;

   assign push     = bus.st_valid && !full;
   assign wr_entry = '{addr: bus.st_addr, data: bus.st_data, size: bus.st_size, valid: 1'b1};

   sb_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .pop      (drain),
      .wr_entry (wr_entry),
      .by_age   (queue),
      .count    (count),
      .full     (full),
      .empty    (empty)
   );

`ifdef SB_FWD_EN
   sb_entry_t youngest;
   logic      fwd_ok;
`endif

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      hit_any = 1'b0;
`ifdef SB_FWD_EN
      youngest = '0;
`endif
      // Scan oldest to youngest so the last match wins as the youngest hitting entry.
      for (int i = 0; i < DEPTH; i++) begin
         if (queue[i].valid && same_word(queue[i].addr, bus.ld_addr)) begin
            hit_any = 1'b1;
`ifdef SB_FWD_EN
            youngest = queue[i];
`endif
         end
      end
   end

   assign hit = bus.ld_req && hit_any;

`ifdef SB_FWD_EN
   assign fwd_ok        = hit && (youngest.size == SZ_W) && (bus.ld_size == SZ_W);
   assign bus.fwd_valid = fwd_ok;
   assign bus.fwd_data  = fwd_ok ? youngest.data : '0;
   assign bus.ld_stall  = hit && !fwd_ok;
   // A forwarded load never needs memory, so the queue keeps draining under it.
   assign port_free     = !bus.ld_req || bus.ld_stall || fwd_ok;
`else
   assign bus.ld_stall  = hit;
   assign port_free     = !bus.ld_req || bus.ld_stall;
`endif

   assign drain = !empty && port_free;

   always_comb begin
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.mem_size  = '0;
      if (drain) begin
         bus.mem_write = 1'b1;
         bus.mem_addr  = queue[0].addr;
         bus.mem_wdata = queue[0].data;
         bus.mem_size  = queue[0].size;
      end else if (bus.ld_req) begin
         bus.mem_read = 1'b1;
         bus.mem_addr = bus.ld_addr;
         bus.mem_size = bus.ld_size;
      end
   end

   assign bus.st_ready = !full;
   assign bus.sb_empty = empty;

endmodule
